// File: rtl/systolic_skew_feeder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : systolic_skew_feeder_if
// Purpose  : Tile control, operand beat and array-edge bundle for the feeder.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface systolic_skew_feeder_if #(
  parameter int ARRAY_SIZE    = 4,
  parameter int IP_DATA_WIDTH = 8,
  parameter int K_WIDTH       = 8
);
  logic                                start;
  logic [K_WIDTH-1:0]                  k_len;
  logic                                busy;
  logic                                in_valid;
  logic                                in_ready;
  logic [ARRAY_SIZE*IP_DATA_WIDTH-1:0] in_row_vec;
  logic [ARRAY_SIZE*IP_DATA_WIDTH-1:0] in_col_vec;
  logic [ARRAY_SIZE*IP_DATA_WIDTH-1:0] out_row;
  logic [ARRAY_SIZE*IP_DATA_WIDTH-1:0] out_col;
  logic                                pe_clear;
  logic                                done;

  modport master (
    output start, k_len, in_valid, in_row_vec, in_col_vec,
    input  busy, in_ready, out_row, out_col, pe_clear, done
  );

  modport slave (
    input  start, k_len, in_valid, in_row_vec, in_col_vec,
    output busy, in_ready, out_row, out_col, pe_clear, done
  );
endinterface
`default_nettype wire

// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : systolic_skew_feeder
// Purpose  : Skews A/B operand slices into a systolic array and sequences
//            one tile (clear, feed, flush, done).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module systolic_skew_feeder #(
  parameter int ARRAY_SIZE    = 4,
  parameter int IP_DATA_WIDTH = 8,
  parameter int K_WIDTH       = 8
) (
  input wire                     clk,
  input wire                     rst,
  systolic_skew_feeder_if.slave  bus
);

  // Skew drain + corner-PE traversal + MAC register stages.
  localparam int c_FLUSH_CYCLES = 3*(ARRAY_SIZE-1) + 2;
  localparam int c_FLUSH_W      = $clog2(c_FLUSH_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [K_WIDTH-1:0]   r_k_len;
  logic [K_WIDTH-1:0]   r_beat_cnt;
  logic [c_FLUSH_W-1:0] r_flush_cnt;
  logic                 w_accept;
  logic                 w_last_beat;
  logic                 w_flush_end;
  logic                 w_busy;
  logic                 w_in_ready;
  logic                 w_pe_clear;
  logic                 w_done;

  assign w_accept    = (r_state == S_FEED) && bus.in_valid;
  assign w_last_beat = w_accept && (r_beat_cnt == (r_k_len - K_WIDTH'(1)));
  assign w_flush_end = (r_flush_cnt == c_FLUSH_W'(c_FLUSH_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b1;
    w_in_ready   = 1'b0;
    w_pe_clear   = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) begin
          // A zero-depth tile has nothing to accumulate, so skip the clear.
          w_next_state = (bus.k_len != '0) ? S_CLEAR : S_DONE;
        end
      end
      S_CLEAR: begin
        w_pe_clear   = 1'b1;
        w_next_state = S_FEED;
      end
      S_FEED: begin
        w_in_ready = 1'b1;
        if (w_last_beat) begin
          w_next_state = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (w_flush_end) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_busy       = 1'b0;
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k_len     <= '0;
      r_beat_cnt  <= '0;
      r_flush_cnt <= '0;
    end else begin
      if ((r_state == S_IDLE) && bus.start) begin
        r_k_len    <= bus.k_len;
        r_beat_cnt <= '0;
      end else if (w_accept && (r_beat_cnt != r_k_len)) begin
        r_beat_cnt <= r_beat_cnt + K_WIDTH'(1);
      end
      r_flush_cnt <= (r_state == S_FLUSH) ? (r_flush_cnt + c_FLUSH_W'(1)) : '0;
    end
  end

  assign bus.busy     = w_busy;
  assign bus.in_ready = w_in_ready;
  assign bus.pe_clear = w_pe_clear;
  assign bus.done     = w_done;

  // Lane i is i+1 registers deep; non-accept cycles push zeros so bubbles
  // stay aligned across lanes.
  for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
    logic [IP_DATA_WIDTH-1:0] r_row_sr [0:gi];
    logic [IP_DATA_WIDTH-1:0] r_col_sr [0:gi];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int j = 0; j <= gi; j++) begin
          r_row_sr[j] <= '0;
          r_col_sr[j] <= '0;
        end
      end else begin
        r_row_sr[0] <= w_accept ? bus.in_row_vec[gi*IP_DATA_WIDTH +: IP_DATA_WIDTH] : '0;
        r_col_sr[0] <= w_accept ? bus.in_col_vec[gi*IP_DATA_WIDTH +: IP_DATA_WIDTH] : '0;
        for (int j = 1; j <= gi; j++) begin
          r_row_sr[j] <= r_row_sr[j-1];
          r_col_sr[j] <= r_col_sr[j-1];
        end
      end
    end

    assign bus.out_row[gi*IP_DATA_WIDTH +: IP_DATA_WIDTH] = r_row_sr[gi];
    assign bus.out_col[gi*IP_DATA_WIDTH +: IP_DATA_WIDTH] = r_col_sr[gi];
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_systolic_skew_feeder
// Purpose  : Randomized self-checking bench for systolic_skew_feeder.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_systolic_skew_feeder;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int KW    = 8;
  localparam int VW    = N*W;
  localparam int FLUSH = 3*(N-1) + 2;

  // Expected {busy, in_ready, pe_clear, done} per phase of a tile.
  localparam logic [3:0] F_IDLE  = 4'b0000;
  localparam logic [3:0] F_CLEAR = 4'b1010;
  localparam logic [3:0] F_FEED  = 4'b1100;
  localparam logic [3:0] F_FLUSH = 4'b1000;
  localparam logic [3:0] F_DONE  = 4'b1001;

  logic clk = 1'b0;
  logic rst = 1'b0;

  systolic_skew_feeder_if #(.ARRAY_SIZE(N), .IP_DATA_WIDTH(W), .K_WIDTH(KW)) bus ();

  systolic_skew_feeder #(.ARRAY_SIZE(N), .IP_DATA_WIDTH(W), .K_WIDTH(KW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;
  int hlen     = 0;

  // Value loaded into every lane head at each counted rising edge.
  logic [VW-1:0] inj_row [0:4095];
  logic [VW-1:0] inj_col [0:4095];
  // Array-edge samples for the current tile, fed to the array model.
  logic [VW-1:0] hr [0:255];
  logic [VW-1:0] hc [0:255];
  int ea [0:63][0:N-1];
  int eb [0:63][0:N-1];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, take the edge, then check the sampled outputs.
  task automatic cycle(input logic v, input logic st, input logic [KW-1:0] kl, input logic acc,
                       input logic [VW-1:0] rv, input logic [VW-1:0] cv, input logic [3:0] flags);
    logic [VW-1:0] er;
    logic [VW-1:0] ec;
    bus.in_valid   = v;
    bus.start      = st;
    bus.k_len      = kl;
    bus.in_row_vec = rv;
    bus.in_col_vec = cv;
    @(posedge clk);
    edge_n++;
    inj_row[edge_n] = acc ? rv : '0;
    inj_col[edge_n] = acc ? cv : '0;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      er[i*W +: W] = (edge_n - i >= 1) ? inj_row[edge_n-i][i*W +: W] : '0;
      ec[i*W +: W] = (edge_n - i >= 1) ? inj_col[edge_n-i][i*W +: W] : '0;
    end
    check_val("out_row", bus.out_row, er);
    check_val("out_col", bus.out_col, ec);
    check_val("flags", {bus.busy, bus.in_ready, bus.pe_clear, bus.done}, flags);
    hr[hlen] = bus.out_row;
    hc[hlen] = bus.out_col;
    if (hlen < 255) hlen++;
  endtask

  // vmode: 0 always valid, 1 valid 0,1,0,1..., 2 random valid
  // dmode: 0 random, 1 A=ones / B=k+1, 2 row {1,2,3,4} col {5,6,7,8}
  task automatic run_tile(input int k, input int vmode, input int dmode,
                          input int abort_at, input bit poke_start);
    int acc_n = 0;
    int guard = 0;
    logic v;
    logic st;
    logic [VW-1:0] rv;
    logic [VW-1:0] cv;
    int obs;
    int expv;
    hlen = 0;
    cycle(1'b0, 1'b1, KW'(k), 1'b0, VW'($urandom), VW'($urandom), (k == 0) ? F_DONE : F_CLEAR);
    if (k == 0) begin
      cycle(1'b0, 1'b0, '0, 1'b0, '0, '0, F_IDLE);
      return;
    end
    hlen = 0;
    // Valid during CLEAR must not be captured.
    cycle(1'($urandom), 1'b0, KW'($urandom), 1'b0, VW'($urandom), VW'($urandom), F_FEED);
    while (acc_n < k) begin
      guard++;
      if (guard > 400) begin
        n_checks++;
        n_fail++;
        $display("FAIL feed_bound: got %0d beats expected %0d", acc_n, k);
        break;
      end
      case (vmode)
        0:       v = 1'b1;
        1:       v = (guard % 2 == 0);
        default: v = 1'($urandom);
      endcase
      rv = VW'($urandom);
      cv = VW'($urandom);
      if (v && dmode == 1) begin
        rv = {N{8'd1}};
        cv = {N{8'(acc_n + 1)}};
      end else if (v && dmode == 2) begin
        rv = {8'd4, 8'd3, 8'd2, 8'd1};
        cv = {8'd8, 8'd7, 8'd6, 8'd5};
      end
      if (v) begin
        for (int i = 0; i < N; i++) begin
          ea[acc_n][i] = int'(rv[i*W +: W]);
          eb[acc_n][i] = int'(cv[i*W +: W]);
        end
        acc_n++;
      end
      st = poke_start && (guard == 2);
      cycle(v, st, KW'($urandom), v, rv, cv, (acc_n == k) ? F_FLUSH : F_FEED);
      if (abort_at >= 0 && acc_n == abort_at) begin
        #1 rst = 1'b1;
        #1;
        check_val("abort_out_row", bus.out_row, '0);
        check_val("abort_out_col", bus.out_col, '0);
        check_val("abort_flags", {bus.busy, bus.in_ready, bus.pe_clear, bus.done}, F_IDLE);
        for (int e = 0; e <= edge_n; e++) begin
          inj_row[e] = '0;
          inj_col[e] = '0;
        end
        cycle(1'b1, 1'b1, KW'(k), 1'b0, VW'($urandom), VW'($urandom), F_IDLE);
        cycle(1'b1, 1'b1, KW'(k), 1'b0, VW'($urandom), VW'($urandom), F_IDLE);
        rst = 1'b0;
        return;
      end
    end
    // Stray valids and starts while flushing must be ignored.
    for (int f = 0; f < FLUSH; f++) begin
      cycle(1'($urandom), 1'($urandom), KW'($urandom), 1'b0, VW'($urandom), VW'($urandom),
            (f == FLUSH - 1) ? F_DONE : F_FLUSH);
    end
    // Output-stationary array: PE(i,j) sees row lane i delayed j and column
    // lane j delayed i; each product needs 2 more cycles to reach its register.
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        obs  = 0;
        expv = 0;
        for (int t = 0; t < hlen; t++) begin
          if (t + j <= hlen - 3 && t + j - i >= 0 && t + j - i < hlen) begin
            obs += int'(hr[t][i*W +: W]) * int'(hc[t + j - i][j*W +: W]);
          end
        end
        for (int kk = 0; kk < k; kk++) expv += ea[kk][i] * eb[kk][j];
        check_val($sformatf("pe_acc_%0d_%0d", i, j), 64'(obs), 64'(expv));
      end
    end
    cycle(1'b0, 1'b0, '0, 1'b0, '0, '0, F_IDLE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int e = 0; e < 4096; e++) begin
      inj_row[e] = '0;
      inj_col[e] = '0;
    end
    bus.start      = 1'b0;
    bus.k_len      = '0;
    bus.in_valid   = 1'b0;
    bus.in_row_vec = '0;
    bus.in_col_vec = '0;
    #2 rst = 1'b1;
    #1;
    check_val("rst_out_row", bus.out_row, '0);
    check_val("rst_out_col", bus.out_col, '0);
    check_val("rst_flags", {bus.busy, bus.in_ready, bus.pe_clear, bus.done}, F_IDLE);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Valid while idle is ignored.
    for (int c = 0; c < 3; c++)
      cycle(1'b1, 1'b0, KW'(4), 1'b0, VW'($urandom), VW'($urandom), F_IDLE);

    run_tile(1, 0, 2, -1, 1'b0);
    run_tile(8, 0, 1, -1, 1'b0);
    run_tile(8, 1, 1, -1, 1'b0);
    run_tile(0, 0, 0, -1, 1'b0);
    run_tile(5, 2, 0, -1, 1'b1);
    run_tile(8, 0, 0, 3, 1'b0);
    run_tile(2, 0, 0, -1, 1'b0);
    for (int r = 0; r < 4; r++)
      run_tile(int'($urandom_range(1, 12)), 2, 0, -1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
